// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the core's data-memory path: widths, arbiter states, ring helper.
package gpu_mem_pkg;

  localparam int unsigned MEM_ADDR_BITS     = 8;
  localparam int unsigned MEM_DATA_BITS     = 8;
  localparam int unsigned MEM_NUM_CONSUMERS = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELEASE
  } mem_arb_state_t;

  // Folds an index in [0, 2n-2] back onto the ring [0, n-1].
  function automatic int unsigned ring_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first pending consumer at or after rr_ptr, wrapping around the ring.
module rr_priority_picker
  import gpu_mem_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = MEM_NUM_CONSUMERS,
  localparam int unsigned PTR_BITS = $clog2(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] pending,
  input  logic [PTR_BITS-1:0]      rr_ptr,
  output logic                     found,
  output logic [PTR_BITS-1:0]      index
);

  logic [PTR_BITS-1:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
      cand = PTR_BITS'(ring_wrap(32'(rr_ptr) + k, NUM_CONSUMERS));
      if (!found && pending[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory read/write port among per-thread LSUs.
module data_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = MEM_ADDR_BITS,
  parameter int unsigned DATA_BITS     = MEM_DATA_BITS,
  parameter int unsigned NUM_CONSUMERS = MEM_NUM_CONSUMERS,
  localparam int unsigned PTR_BITS = $clog2(NUM_CONSUMERS)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready
);

  mem_arb_state_t      state_q;
  logic [PTR_BITS-1:0] rr_ptr_q;
  logic [PTR_BITS-1:0] grant_q;
  logic [PTR_BITS-1:0] grant_succ;
  logic [PTR_BITS-1:0] pick;
  logic                found;

  rr_priority_picker #(
    .NUM_CONSUMERS(NUM_CONSUMERS)
  ) u_picker (
    .pending(consumer_read_valid | consumer_write_valid),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .index  (pick)
  );

  assign grant_succ = (grant_q == PTR_BITS'(NUM_CONSUMERS - 1)) ? '0
                                                                : grant_q + PTR_BITS'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= IDLE;
      rr_ptr_q             <= '0;
      grant_q              <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= pick;
            // A consumer raising both valids gets its read first.
            if (consumer_read_valid[pick]) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[pick];
              state_q          <= READ_WAIT;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[pick];
              mem_write_data    <= consumer_write_data[pick];
              state_q           <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid               <= 1'b0;
            consumer_read_data[grant_q]  <= mem_read_data;
            consumer_read_ready[grant_q] <= 1'b1;
            rr_ptr_q                     <= grant_succ;
            state_q                      <= RELEASE;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid               <= 1'b0;
            consumer_write_ready[grant_q] <= 1'b1;
            rr_ptr_q                      <= grant_succ;
            state_q                       <= RELEASE;
          end
        end
        RELEASE: begin
          consumer_read_ready  <= '0;
          consumer_write_ready <= '0;
          // Wait for the served consumer to retract so its request is not issued twice.
          if (!consumer_read_valid[grant_q] && !consumer_write_valid[grant_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
